// File: rtl/sd_block_sequencer.sv
// Single-block SD transfer engine: drives the sdc_controller Wishbone
// register port through the CMD17/CMD24 setup, event polling and event
// clearing sequence, and reports one done pulse with a sticky error code.
module sd_block_sequencer #(
  parameter logic [7:0]  REG_ARG      = 8'h00,
  parameter logic [7:0]  REG_CMD      = 8'h04,
  parameter logic [7:0]  REG_CMD_ISR  = 8'h34,
  parameter logic [7:0]  REG_DAT_ISR  = 8'h3C,
  parameter logic [7:0]  REG_BLKCNT   = 8'h48,
  parameter logic [7:0]  REG_DMA      = 8'h60,
  parameter logic [31:0] DMA_BASE     = 32'h0,
  parameter logic [31:0] CMD_RD       = 32'h0000_1139,
  parameter logic [31:0] CMD_WR       = 32'h0000_1859,
  parameter logic [31:0] CMD_ERR_MASK = 32'h0000_001E,
  parameter logic [31:0] DAT_ERR_MASK = 32'h0000_0006,
  parameter int          TMO_W        = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_lba,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [31:0] err_status,
  output logic [7:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i
);

  typedef enum logic [3:0] {
    S_IDLE, S_W_DMA, S_W_BCNT, S_W_ARG, S_W_CMD,
    S_P_CEVT, S_C_CEVT, S_P_DEVT, S_C_DEVT, S_DONE
  } state_t;

  // Last count value before the limit: the read that would bring the
  // counter to all-ones is the one that declares the timeout.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t           state_q, state_d;
  logic             write_q, write_d;
  logic [31:0]      lba_q, lba_d;
  logic             cyc_q, cyc_d;
  logic             we_q, we_d;
  logic [7:0]       adr_q, adr_d;
  logic [31:0]      dat_q, dat_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [1:0]       code_q, code_d;
  logic [31:0]      status_q, status_d;

  logic [7:0]       acc_adr;
  logic [31:0]      acc_dat;
  logic             acc_we;

  // State and bus registers; reset drops any open cycle on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      lba_q    <= '0;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      tmo_q    <= '0;
      code_q   <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      lba_q    <= lba_d;
      cyc_q    <= cyc_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      tmo_q    <= tmo_d;
      code_q   <= code_d;
      status_q <= status_d;
    end
  end

  // Next state: each access state opens one WB cycle while the bus is idle,
  // and acts on the ack; closing at the ack edge gives the idle gap for free.
  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    lba_d    = lba_q;
    cyc_d    = cyc_q;
    we_d     = we_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    tmo_d    = tmo_q;
    code_d   = code_q;
    status_d = status_q;
    acc_adr  = '0;
    acc_dat  = '0;
    acc_we   = 1'b0;

    case (state_q)
      S_W_DMA:  begin acc_adr = REG_DMA;     acc_dat = DMA_BASE; acc_we = 1'b1; end
      S_W_BCNT: begin acc_adr = REG_BLKCNT;  acc_dat = '0;       acc_we = 1'b1; end
      S_W_ARG:  begin acc_adr = REG_ARG;     acc_dat = lba_q;    acc_we = 1'b1; end
      S_W_CMD:  begin acc_adr = REG_CMD;     acc_dat = write_q ? CMD_WR : CMD_RD; acc_we = 1'b1; end
      S_P_CEVT: begin acc_adr = REG_CMD_ISR; acc_we = 1'b0; end
      S_C_CEVT: begin acc_adr = REG_CMD_ISR; acc_we = 1'b1; end
      S_P_DEVT: begin acc_adr = REG_DAT_ISR; acc_we = 1'b0; end
      S_C_DEVT: begin acc_adr = REG_DAT_ISR; acc_we = 1'b1; end
      default: ;
    endcase

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          lba_d    = req_lba;
          code_d   = '0;
          status_d = '0;
          state_d  = S_W_DMA;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          adr_d = acc_adr;
          dat_d = acc_dat;
          we_d  = acc_we;
        end else if (wb_ack_i) begin
          cyc_d = 1'b0;
          case (state_q)
            S_W_DMA:  state_d = S_W_BCNT;
            S_W_BCNT: state_d = S_W_ARG;
            S_W_ARG:  state_d = S_W_CMD;
            S_W_CMD: begin
              tmo_d   = '0;
              state_d = S_P_CEVT;
            end
            S_P_CEVT: begin
              if (wb_dat_i != '0) begin
                if ((wb_dat_i & CMD_ERR_MASK) != '0) begin
                  code_d   = 2'd1;
                  status_d = wb_dat_i;
                end
                state_d = S_C_CEVT;
              end else if (tmo_q == TMO_LAST) begin
                code_d   = 2'd3;
                status_d = wb_dat_i;
                state_d  = S_DONE;
              end else begin
                tmo_d = tmo_q + 1'b1;
              end
            end
            S_C_CEVT: begin
              tmo_d   = '0;
              state_d = (code_q != '0) ? S_DONE : S_P_DEVT;
            end
            S_P_DEVT: begin
              if (wb_dat_i != '0) begin
                if ((wb_dat_i & DAT_ERR_MASK) != '0) begin
                  code_d   = 2'd2;
                  status_d = wb_dat_i;
                end
                state_d = S_C_DEVT;
              end else if (tmo_q == TMO_LAST) begin
                code_d   = 2'd3;
                status_d = wb_dat_i;
                state_d  = S_DONE;
              end else begin
                tmo_d = tmo_q + 1'b1;
              end
            end
            S_C_DEVT: state_d = S_DONE;
            default:  state_d = S_IDLE;
          endcase
        end
      end
    endcase
  end

  assign req_ready  = (state_q == S_IDLE);
  assign done       = (state_q == S_DONE);
  assign err        = (code_q != '0);
  assign err_code   = code_q;
  assign err_status = status_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_we_o    = we_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign wb_sel_o   = 4'hf;

endmodule
